motor_enc_sampler: RTL
======================

Name: motor_enc_sampler

Overview:
- Downstream feedback stage of the two-wheel PWM motor controller.
- Decodes the left and right quadrature encoders (x4 decoding).
- Accumulates signed position deltas over a fixed sample window.
- At each window end, packs both deltas into one 32-bit word and writes it into the controller's 32-bit output FIFO (snd_data/snd_en/full interface), where host software reads it back as odometry.

Parameters:
- SAMPLE_PERIOD, 100000: window length in clk cycles (>= 4).
- SYNC_STAGES, 2: flip-flop stages synchronising each asynchronous encoder input (>= 2).
- DROP_W, 8: width of the dropped-sample counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  level; 1 = measure and emit words; 0 = idle and clear.
- enc_a_left  in  1  left encoder channel A (asynchronous).
- enc_b_left  in  1  left encoder channel B (asynchronous).
- enc_a_right  in  1  right encoder channel A (asynchronous).
- enc_b_right  in  1  right encoder channel B (asynchronous).
- snd_full  in  1  output FIFO full flag.
- snd_data  out  32  [15:0] left delta, [31:16] right delta, two's complement.
- snd_en  out  1  FIFO write strobe, one cycle.
- err_left  out  1  sticky: illegal left transition seen.
- err_right  out  1  sticky: illegal right transition seen.
- drop_cnt  out  DROP_W  words lost because FIFO was full; saturating.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, all outputs are 0, synchronisers and previous-AB registers are 0, accumulators and period counter are 0, FSM is IDLE. Reset mid-window discards the partial window.
- Synchronisation: each encoder input passes through SYNC_STAGES flops. The decoder compares the synchronised {A,B} with the previous cycle's {A,B}.
- Decode, per wheel:
  - Forward (+1): 00->01->11->10->00.
  - Reverse (-1): the opposite order.
  - No change: 0.
  - Both bits change (00<->11, 01<->10): illegal; count 0 and set the err flag. The err flag is cleared only by rst.
- Accumulator: signed 16-bit, saturating at +32767 / -32768 (no wrap).
- FSM states are IDLE, COUNT, PUSH.
  - IDLE: accumulators and period counter held at 0. Goes to COUNT when sample_en=1.
  - COUNT: period counter runs 0..SAMPLE_PERIOD-1 and the accumulators update.
    - On the cycle the counter equals SAMPLE_PERIOD-1: latch the packed word into snd_data, load each accumulator with that cycle's increment (0/+1/-1) so no edge is lost, reset the counter to 0, and go to PUSH.
    - If sample_en=0: go to IDLE and clear the accumulators.
  - PUSH (one cycle): snd_en = !snd_full.
    - If snd_full=1, no write and drop_cnt increments (saturating at all-ones).
    - Counting continues during PUSH as normal COUNT cycle 0.
    - Next state is COUNT if sample_en=1, else IDLE. A PUSH already entered completes even if sample_en falls.
- Latency: snd_en is asserted exactly 1 cycle after the terminal-count cycle. An encoder edge affects the accumulator SYNC_STAGES+1 cycles after the pin changes.
- snd_data holds its last latched value between pushes.

Decomposition:
- Package motor_pkg:
  - FSM state encoding (IDLE/COUNT/PUSH).
  - Word field offsets (LEFT_LSB=0, RIGHT_LSB=16, DELTA_W=16).
  - Saturation limits DELTA_MAX/DELTA_MIN.
- Sub-module quad_decoder, instantiated once per wheel:
  - Contains the synchroniser, previous-AB register and transition decode.
  - Outputs one-cycle inc, dec and err pulses.
  - The top level holds the accumulators, period counter, FSM and FIFO handshake.

Test Plan:
- Run all tests with SAMPLE_PERIOD=100 unless stated.
1. Reset held 3 cycles with encoders toggling -> all outputs 0; no snd_en during reset or in the first window after release.
2. sample_en=1; left forward 40 edges (10 full cycles, one edge per 2 clk); right static -> exactly one snd_en pulse, snd_data=0x0000_0028, err flags 0.
3. Right reverse 5 edges in one window; left static -> snd_data=0xFFFB_0000; next window with no edges -> snd_data=0x0000_0000.
4. Left AB 00 -> 11 in one step -> err_left=1 and stays 1; that window's left delta = 0; err_right=0.
5. snd_full=1 at two consecutive window ends -> snd_en never asserted, drop_cnt=2. Release full -> next window writes normally.
6. SAMPLE_PERIOD=70000; left forward edge every 2 clk -> left delta saturates at 0x7FFF, no wrap. Edge placed on the terminal-count cycle -> counted in the following window.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the encoder sampler: FSM encoding, output word layout,
// delta saturation limits and the quadrature decode helpers.
package motor_pkg;

   typedef enum logic [1:0] {StIdle, StCount, StPush} state_e;

   localparam int unsigned LEFT_LSB  = 0;
   localparam int unsigned RIGHT_LSB = 16;
   localparam int unsigned DELTA_W   = 16;

   localparam logic signed [DELTA_W-1:0] DELTA_MAX = 16'sh7FFF;
   localparam logic signed [DELTA_W-1:0] DELTA_MIN = 16'sh8000;

   // Position of an {A,B} pair along the forward sequence 00->01->11->10.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      logic [1:0] idx;
      unique case (ab)
         2'b00:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         2'b11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   function automatic logic signed [DELTA_W-1:0] sat_step(input logic signed [DELTA_W-1:0] acc,
                                                          input logic inc,
                                                          input logic dec);
      logic signed [DELTA_W-1:0] res;
      res = acc;
      if (inc && (acc != DELTA_MAX)) begin
         res = acc + 16'sd1;
      end else if (dec && (acc != DELTA_MIN)) begin
         res = acc - 16'sd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/motor_enc_sampler_if.sv
// Write side of the controller's 32-bit output FIFO.
interface motor_enc_sampler_if;
   logic [31:0] snd_data;
   logic        snd_en;
   logic        snd_full;

   modport master (output snd_data, output snd_en, input snd_full);
   modport slave  (input snd_data, input snd_en, output snd_full);
endinterface

// File: rtl/quad_decoder.sv
// One quadrature channel: input synchroniser, previous-AB register and x4 transition decode
// into single-cycle inc/dec/err pulses.
module quad_decoder
   import motor_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic enc_a,
   input  logic enc_b,
   output logic inc,
   output logic dec,
   output logic err
);

   logic [SYNC_STAGES-1:0] sync_a_q;
   logic [SYNC_STAGES-1:0] sync_b_q;
   logic [1:0]             ab_cur;
   logic [1:0]             ab_prev_q;
   logic [1:0]             step;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a_q  <= '0;
         sync_b_q  <= '0;
         ab_prev_q <= '0;
      end else begin
         sync_a_q  <= {sync_a_q[SYNC_STAGES-2:0], enc_a};
         sync_b_q  <= {sync_b_q[SYNC_STAGES-2:0], enc_b};
         ab_prev_q <= ab_cur;
      end
   end

   assign ab_cur = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

   // Modulo-4 distance along the sequence: 1 forward, 3 reverse, 2 means both bits flipped.
   assign step = gray_idx(ab_cur) - gray_idx(ab_prev_q);
   assign inc  = (step == 2'd1);
   assign dec  = (step == 2'd3);
   assign err  = (step == 2'd2);

endmodule

// File: rtl/motor_enc_sampler.sv
// Two-wheel odometry sampler: accumulates signed encoder deltas over a fixed window and
// writes one packed {right, left} word per window into the output FIFO.
module motor_enc_sampler
   import motor_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD = 100000,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DROP_W        = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_en,
   input  logic                   enc_a_left,
   input  logic                   enc_b_left,
   input  logic                   enc_a_right,
   input  logic                   enc_b_right,
   motor_enc_sampler_if.master    snd,
   output logic                   err_left,
   output logic                   err_right,
   output logic [DROP_W-1:0]      drop_cnt
);

   localparam int unsigned       CNT_W    = $clog2(SAMPLE_PERIOD);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

   logic inc_l, dec_l, err_l;
   logic inc_r, dec_r, err_r;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [DELTA_W-1:0] acc_l_q, acc_l_d;
   logic signed [DELTA_W-1:0] acc_r_q, acc_r_d;
   logic [31:0]               data_q, data_d;
   logic [31:0]               word;
   logic [DROP_W-1:0]         drop_q, drop_d;
   logic                      err_l_q, err_r_q;
   logic                      snd_en_c;

   quad_decoder #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_dec_left (
      .clk   (clk),
      .rst   (rst),
      .enc_a (enc_a_left),
      .enc_b (enc_b_left),
      .inc   (inc_l),
      .dec   (dec_l),
      .err   (err_l)
   );

   quad_decoder #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_dec_right (
      .clk   (clk),
      .rst   (rst),
      .enc_a (enc_a_right),
      .enc_b (enc_b_right),
      .inc   (inc_r),
      .dec   (dec_r),
      .err   (err_r)
   );

   always_comb begin
      word = '0;
      word[LEFT_LSB  +: DELTA_W] = acc_l_q;
      word[RIGHT_LSB +: DELTA_W] = acc_r_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;
      data_d   = data_q;
      drop_d   = drop_q;
      snd_en_c = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d   = '0;
            acc_l_d = '0;
            acc_r_d = '0;
            if (sample_en) state_d = StCount;
         end
         StCount: begin
            if (!sample_en) begin
               state_d = StIdle;
               cnt_d   = '0;
               acc_l_d = '0;
               acc_r_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               // This cycle's edge seeds the next window rather than being lost.
               data_d  = word;
               acc_l_d = sat_step('0, inc_l, dec_l);
               acc_r_d = sat_step('0, inc_r, dec_r);
               cnt_d   = '0;
               state_d = StPush;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               acc_l_d = sat_step(acc_l_q, inc_l, dec_l);
               acc_r_d = sat_step(acc_r_q, inc_r, dec_r);
            end
         end
         StPush: begin
            snd_en_c = !snd.snd_full;
            if (snd.snd_full && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
            if (sample_en) begin
               state_d = StCount;
               cnt_d   = cnt_q + CNT_W'(1);
               acc_l_d = sat_step(acc_l_q, inc_l, dec_l);
               acc_r_d = sat_step(acc_r_q, inc_r, dec_r);
            end else begin
               state_d = StIdle;
               cnt_d   = '0;
               acc_l_d = '0;
               acc_r_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         data_q  <= '0;
         drop_q  <= '0;
         err_l_q <= 1'b0;
         err_r_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
         err_l_q <= err_l_q | err_l;
         err_r_q <= err_r_q | err_r;
      end
   end

   assign snd.snd_data = data_q;
   assign snd.snd_en   = snd_en_c;
   assign err_left     = err_l_q;
   assign err_right    = err_r_q;
   assign drop_cnt     = drop_q;

endmodule
